// File: rtl/irq_pending_collector.sv
// Interrupt pending collector: captures rising request edges into a pending
// register, presents unmasked pending bits to a downstream priority encoder,
// raises irq while armed, and enforces a holdoff window after each ack.
module irq_pending_collector #(
   parameter int unsigned HOLDOFF = 2
) (
   input  logic       clk,
   input  logic       areset_n,
   input  logic [7:0] req,
   input  logic [7:0] mask,
   input  logic       ack,
   input  logic [2:0] pos,
   input  logic       ovr_clr,
   output logic [7:0] pend,
   output logic       irq,
   output logic [7:0] overrun,
   output logic       ack_err
);

   localparam int unsigned N     = 8;
   localparam int unsigned CNT_W = 4;

   // First counter value on entering HOLD; unused when HOLDOFF is zero
   localparam logic [CNT_W-1:0] HOLD_INIT =
      (HOLDOFF == 0) ? '0 : CNT_W'(HOLDOFF - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [N-1:0]     req_q;
   logic [N-1:0]     p_q;

   logic [N-1:0]     req_edge;
   logic [N-1:0]     clr;
   logic [N-1:0]     ovr_set;
   logic [N-1:0]     p_next;
   logic [N-1:0]     ovr_next;
   logic             accept;
   logic             pos_hit;

   // Masked view of the pending set for the downstream encoder
   assign pend = p_q & ~mask;

   // Edge detect, ack clear, and overrun detection for the next cycle
   always_comb begin
      req_edge = req & ~req_q;
      accept   = (state == ARMED) && ack;
      pos_hit  = pend[pos];
      clr      = '0;
      if (accept && pos_hit) begin
         clr = N'(1) << pos;
      end
      // A new edge on a bit being cleared re-sets it and is not an overrun
      p_next   = (p_q & ~clr) | req_edge;
      ovr_set  = req_edge & p_q & ~clr;
      ovr_next = (ovr_clr ? '0 : overrun) | ovr_set;
   end

   // Request history, pending set and sticky overrun flags
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         req_q   <= '0;
         p_q     <= '0;
         overrun <= '0;
      end else begin
         req_q   <= req;
         p_q     <= p_next;
         overrun <= ovr_next;
      end
   end

   // Arm/holdoff sequencer with registered irq and ack_err
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         irq     <= 1'b0;
         ack_err <= 1'b0;
      end else begin
         ack_err <= 1'b0;
         case (state)
            IDLE: begin
               if (pend != '0) begin
                  state <= ARMED;
                  irq   <= 1'b1;
               end
            end
            ARMED: begin
               if (ack) begin
                  ack_err <= !pos_hit;
                  irq     <= 1'b0;
                  if (HOLDOFF == 0) begin
                     state <= IDLE;
                  end else begin
                     state <= HOLD;
                     cnt   <= HOLD_INIT;
                  end
               end else if (pend == '0) begin
                  state <= IDLE;
                  irq   <= 1'b0;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               irq   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_pending_collector.sv
// Self-checking bench for irq_pending_collector: a behavioural model checked
// every cycle, plus hand-computed expectations along a directed sequence.
module tb_irq_pending_collector;

   localparam int unsigned HOLDOFF = 2;

   logic       clk = 1'b0;
   logic       areset_n = 1'b0;
   logic [7:0] req = '0;
   logic [7:0] mask = '0;
   logic       ack = 1'b0;
   logic [2:0] pos = '0;
   logic       ovr_clr = 1'b0;
   logic [7:0] pend;
   logic       irq;
   logic [7:0] overrun;
   logic       ack_err;

   int checks = 0;
   int failures = 0;
   logic chk_en = 1'b0;

   irq_pending_collector #(.HOLDOFF(HOLDOFF)) dut (
      .clk      (clk),
      .areset_n (areset_n),
      .req      (req),
      .mask     (mask),
      .ack      (ack),
      .pos      (pos),
      .ovr_clr  (ovr_clr),
      .pend     (pend),
      .irq      (irq),
      .overrun  (overrun),
      .ack_err  (ack_err)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   logic [7:0] m_p = '0;
   logic [7:0] m_prev = '0;
   logic [7:0] m_ovr = '0;
   logic       m_irq = 1'b0;
   logic       m_err = 1'b0;
   int         m_hold = 0;
   logic [7:0] mv_pm, mv_rise, mv_clr;
   logic       mv_acc, mv_hit;

   always @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         m_p = '0; m_prev = '0; m_ovr = '0;
         m_irq = 1'b0; m_err = 1'b0; m_hold = 0;
      end else begin
         mv_pm   = m_p & ~mask;
         mv_rise = req & ~m_prev;
         mv_acc  = m_irq && ack;
         mv_hit  = mv_pm[pos];
         mv_clr  = '0;
         if (mv_acc && mv_hit) mv_clr[pos] = 1'b1;
         m_ovr   = (ovr_clr ? 8'h00 : m_ovr) | (mv_rise & m_p & ~mv_clr);
         m_p     = (m_p & ~mv_clr) | mv_rise;
         m_prev  = req;
         m_err   = mv_acc && !mv_hit;
         if (mv_acc) begin
            m_irq  = 1'b0;
            m_hold = HOLDOFF;
         end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
            m_irq  = 1'b0;
         end else begin
            m_irq = (mv_pm != 8'h00);
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_pend", pend, m_p & ~mask);
         chk("model_irq", {7'd0, irq}, {7'd0, m_irq});
         chk("model_overrun", overrun, m_ovr);
         chk("model_ack_err", {7'd0, ack_err}, {7'd0, m_err});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_irq(input string name);
      int n;
      n = 0;
      while (irq !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk(name, {7'd0, irq}, 8'h01);
   endtask

   task automatic settle();
      for (int i = 0; i < 4; i++) tick();
   endtask

   initial begin
      // Reset state
      #3;
      chk_en = 1'b1;
      #20;
      chk("rst_pend", pend, 8'h00);
      chk("rst_irq", {7'd0, irq}, 8'h00);
      chk("rst_overrun", overrun, 8'h00);
      areset_n = 1'b1;
      tick();

      // Single source: latency and ack clear
      req = 8'h08;
      tick();
      chk("t1_pend_set", pend, 8'h08);
      chk("t1_irq_early", {7'd0, irq}, 8'h00);
      tick();
      chk("t1_irq_up", {7'd0, irq}, 8'h01);
      ack = 1'b1; pos = 3'd3;
      tick();
      ack = 1'b0;
      chk("t1_pend_clr", pend, 8'h00);
      chk("t1_irq_down", {7'd0, irq}, 8'h00);
      settle();
      req = 8'h00;
      settle();

      // Two sources: holdoff window between services
      req = 8'h81;
      tick();
      chk("t2_pend", pend, 8'h81);
      tick();
      chk("t2_irq", {7'd0, irq}, 8'h01);
      ack = 1'b1; pos = 3'd0;
      tick();
      ack = 1'b0;
      chk("t2_pend_after", pend, 8'h80);
      chk("t2_hold_a", {7'd0, irq}, 8'h00);
      tick();
      chk("t2_hold_b", {7'd0, irq}, 8'h00);
      tick();
      chk("t2_hold_c", {7'd0, irq}, 8'h00);
      tick();
      chk("t2_rearm", {7'd0, irq}, 8'h01);
      ack = 1'b1; pos = 3'd7;
      tick();
      ack = 1'b0;
      chk("t2_pend_empty", pend, 8'h00);
      settle();
      req = 8'h00;
      settle();

      // Overrun, overrun clear, and set-wins-over-clear
      req = 8'h04;
      tick();
      req = 8'h00;
      tick();
      req = 8'h04;
      tick();
      chk("t3_overrun", overrun, 8'h04);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("t3_ovr_clr", overrun, 8'h00);
      req = 8'h00;
      tick();
      chk("t3_armed", {7'd0, irq}, 8'h01);
      req = 8'h04; ack = 1'b1; pos = 3'd2;
      tick();
      ack = 1'b0;
      chk("t3_set_wins", pend, 8'h04);
      chk("t3_no_ovr", overrun, 8'h00);
      wait_irq("t3_rearm");
      ack = 1'b1; pos = 3'd2;
      tick();
      ack = 1'b0;
      req = 8'h00;
      settle();
      chk("t3_pend_empty", pend, 8'h00);

      // Masking drops back to idle, unmasking re-arms
      req = 8'h10;
      tick();
      tick();
      chk("t4_irq", {7'd0, irq}, 8'h01);
      mask = 8'h10;
      #1;
      chk("t4_pend_masked", pend, 8'h00);
      tick();
      chk("t4_idle", {7'd0, irq}, 8'h00);
      tick();
      chk("t4_idle2", {7'd0, irq}, 8'h00);
      mask = 8'h00;
      #1;
      chk("t4_pend_back", pend, 8'h10);
      tick();
      chk("t4_rearm", {7'd0, irq}, 8'h01);
      ack = 1'b1; pos = 3'd4;
      tick();
      ack = 1'b0;
      req = 8'h00;
      settle();

      // Ack to a non-pending source, then acks ignored during holdoff
      req = 8'h02;
      tick();
      tick();
      chk("t5_irq", {7'd0, irq}, 8'h01);
      ack = 1'b1; pos = 3'd5;
      tick();
      chk("t5_ack_err", {7'd0, ack_err}, 8'h01);
      chk("t5_pend_kept", pend, 8'h02);
      pos = 3'd1;
      tick();
      chk("t5_err_pulse", {7'd0, ack_err}, 8'h00);
      chk("t5_hold_ign", pend, 8'h02);
      tick();
      chk("t5_hold_ign2", pend, 8'h02);
      ack = 1'b0;
      wait_irq("t5_rearm");
      ack = 1'b1; pos = 3'd1;
      tick();
      ack = 1'b0;
      req = 8'h00;
      settle();

      // Asynchronous reset in the middle of holdoff
      req = 8'h66;
      tick();
      tick();
      ack = 1'b1; pos = 3'd0;
      tick();
      ack = 1'b0;
      chk("t6_pend_pre", pend, 8'h66);
      req = 8'h01;
      #2;
      areset_n = 1'b0;
      #1;
      chk("t6_rst_pend", pend, 8'h00);
      chk("t6_rst_irq", {7'd0, irq}, 8'h00);
      chk("t6_rst_ovr", overrun, 8'h00);
      chk("t6_rst_err", {7'd0, ack_err}, 8'h00);
      @(negedge clk);
      #2;
      areset_n = 1'b1;
      tick();
      chk("t6_first_edge", pend, 8'h01);
      tick();
      chk("t6_irq", {7'd0, irq}, 8'h01);
      tick();

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
